tape_loader: RTL
================

TAPE_LOADER -- requirements
Module: tape_loader

Interface
REQ-001 SHALL have parameter CELLS, default 8, giving the number of tape cells; head width is clog2(CELLS).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port switch, input, 8 bits: operand source; bits [CELLS-2:0] are used, LSB first.
REQ-005 SHALL have port load, input, 1 bit: debounced centre button, level; only its rising edge acts.
REQ-006 SHALL have port head, output, 3 bits: tape cell address, shared by all tapes.
REQ-007 SHALL have port write_ena, output, 3 bits: per-tape write enable; bit0 = tape 0, bit1 = tape 1, bit2 = sum tape.
REQ-008 SHALL have port write_data, output, 2 bits: tape symbol being written.
REQ-009 SHALL have port busy, output, 1 bit: high while any tape is being written.
REQ-010 SHALL have port done, output, 1 bit: high while both operands are loaded and the sum tape is blank.

Function
REQ-011 SHALL implement states WAIT_A, LOAD_A, WAIT_B, LOAD_B, CLEAR_S, DONE.
REQ-012 SHALL detect a rising edge of load as load=1 this cycle and load=0 the previous cycle (registered).
REQ-013 On a load edge in WAIT_A or DONE, SHALL capture switch into an internal operand register, clear the head counter, and enter LOAD_A next cycle.
REQ-014 On a load edge in WAIT_B, SHALL capture switch, clear the head counter, and enter LOAD_B.
REQ-015 In LOAD_A/LOAD_B, SHALL write one cell per cycle, with head = 0..CELLS-1 and write_ena = 3'b001 or 3'b010 respectively.
REQ-016 In LOAD_A/LOAD_B, cell k < CELLS-1 SHALL receive ONE if operand[k]=1, else ZERO; cell CELLS-1 SHALL receive B.
REQ-017 In CLEAR_S, SHALL write B to sum-tape cells 0..CELLS-1, with write_ena = 3'b100.
REQ-018 After the write to cell CELLS-1: LOAD_A SHALL go to WAIT_B, LOAD_B SHALL go to CLEAR_S, and CLEAR_S SHALL go to DONE.
REQ-019 Each load or clear phase SHALL take exactly CELLS cycles.
REQ-020 After the final write, head SHALL return to 0 on the next cycle, so the consumer starts at cell 0.
REQ-021 Outside write states, write_ena SHALL be 3'b000 and write_data SHALL be B.
REQ-022 Load edges SHALL be ignored during LOAD_A, LOAD_B and CLEAR_S; a button still held at the end of a phase SHALL NOT retrigger.
REQ-023 Changes on switch after capture SHALL NOT affect tape contents.
REQ-024 busy SHALL equal (state is LOAD_A, LOAD_B or CLEAR_S); done SHALL equal (state == DONE).
REQ-025 Head counter arithmetic SHALL wrap modulo 2^3, but no state SHALL ever issue head >= CELLS.

Reset
REQ-026 rst high SHALL immediately force state=WAIT_A, head=0, write_ena=0, write_data=B, busy=0, done=0, operand=0, edge register=0.
REQ-027 Reset asserted mid-phase SHALL abort the phase with no further writes; cells already written are not restored.
REQ-028 A load held high across reset release SHALL NOT count as an edge.

Structure
REQ-029 Tape symbol encodings (ZERO=2'b00, ONE=2'b01, B=2'b10) and state encodings SHALL live in the shared FSM defines file, also used by the adder FSM and the tape.
REQ-030 SHALL instantiate one sub-module, edge_detect (clk, rst, in, rise), for load.

Verification
REQ-031 Reset, switch=8'h05, one load pulse -> on 8 consecutive cycles, head 0..7, write_ena=001, data ONE,ZERO,ONE,ZERO,ZERO,ZERO,ZERO,B; then state WAIT_B, busy=0.
REQ-032 Then switch=8'h7F, one pulse -> tape 1 gets ONE×7 then B, followed by 8 cycles of write_ena=100 with data B; then done=1, head=0.
REQ-033 Load held high for 30 cycles from WAIT_A -> exactly one LOAD_A phase, and no LOAD_B entry.
REQ-034 Pulse during LOAD_A, and switch toggled mid-phase -> ignored; tape 0 matches the captured value.
REQ-035 rst asserted at cycle 3 of LOAD_B -> same cycle write_ena=000, state WAIT_A, done=0; the next pulse writes tape 0.
REQ-036 Pulse in DONE with switch=8'h00 -> restarts LOAD_A writing ZERO×7, B; done falls on entry.

Source files
------------

// File: rtl/tape_loader_pkg.sv
// Shared FSM defines: tape symbol encodings and loader state encodings,
// used by the loader, the adder FSM and the tape storage.
package tape_loader_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'b00,
    SYM_ONE  = 2'b01,
    SYM_B    = 2'b10
  } sym_t;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    LOAD_A  = 3'd1,
    WAIT_B  = 3'd2,
    LOAD_B  = 3'd3,
    CLEAR_S = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] WE_NONE  = 3'b000;
  localparam logic [2:0] WE_TAPE0 = 3'b001;
  localparam logic [2:0] WE_TAPE1 = 3'b010;
  localparam logic [2:0] WE_SUM   = 3'b100;

endpackage

// File: rtl/tape_loader_edge_detect.sv
// Rising-edge detector for the debounced load button. The detector is disarmed
// for the first cycle after reset so a button held across reset release is not an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev  <= in;
      armed <= 1'b1;
    end
  end

  assign rise = armed & in & ~prev;

endmodule

// File: rtl/tape_loader.sv
// Loads two operands from the switches onto tapes 0 and 1 (LSB first, blank
// terminated), then blanks the sum tape, one cell per clock.
module tape_loader
  import tape_loader_pkg::*;
#(
  parameter int CELLS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switch,
  input  logic       load,
  output logic [2:0] head,
  output logic [2:0] write_ena,
  output logic [1:0] write_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST = 3'(CELLS - 1);

  state_t     state, state_d;
  logic [2:0] head_q, head_d;
  logic [7:0] operand, operand_d;
  logic       load_rise;

  edge_detect u_load_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (load),
    .rise (load_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_A;
      head_q  <= 3'd0;
      operand <= 8'd0;
    end else begin
      state   <= state_d;
      head_q  <= head_d;
      operand <= operand_d;
    end
  end

  always_comb begin
    state_d    = state;
    head_d     = head_q;
    operand_d  = operand;
    write_ena  = WE_NONE;
    write_data = SYM_B;
    case (state)
      WAIT_A, DONE: begin
        if (load_rise) begin
          operand_d = switch;
          head_d    = 3'd0;
          state_d   = LOAD_A;
        end
      end
      WAIT_B: begin
        if (load_rise) begin
          operand_d = switch;
          head_d    = 3'd0;
          state_d   = LOAD_B;
        end
      end
      LOAD_A, LOAD_B, CLEAR_S: begin
        write_ena = (state == LOAD_A) ? WE_TAPE0 :
                    (state == LOAD_B) ? WE_TAPE1 : WE_SUM;
        // Last cell of an operand tape is the blank terminator.
        if (state != CLEAR_S && head_q != LAST)
          write_data = operand[head_q] ? SYM_ONE : SYM_ZERO;
        if (head_q == LAST) begin
          head_d  = 3'd0;
          state_d = (state == LOAD_A) ? WAIT_B :
                    (state == LOAD_B) ? CLEAR_S : DONE;
        end else begin
          head_d = head_q + 3'd1;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign head = head_q;
  assign busy = (state == LOAD_A) || (state == LOAD_B) || (state == CLEAR_S);
  assign done = (state == DONE);

endmodule
